// File: rtl/risc_spm_pkg.sv
// ---------------------------------------------------------------------------
// risc_spm_pkg
// Shared definitions for the RISC-SPM memory subsystem.
//   word_size    : address and data width of the program/data memory
//   arb_state_t  : memory port arbiter state codes
//   port_id_t    : identifies which requester owns a grant
// ---------------------------------------------------------------------------
package risc_spm_pkg;

  localparam int word_size = 8;

  typedef enum logic [1:0] {
    S_RR    = 2'd0,
    S_LOCK  = 2'd1,
    S_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_id_t;

endpackage

// File: rtl/arb_wait_counter.sv
// ---------------------------------------------------------------------------
// arb_wait_counter
// Saturating starvation counter for the memory port arbiter. Counts the
// cycles a requester has been refused and flags when the limit is reached.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active-low
//   inc     : count one more refused cycle
//   clr     : clear the count (wins over inc)
//   at_max  : count has reached MAX_WAIT
// ---------------------------------------------------------------------------
module arb_wait_counter #(
  parameter int WAIT_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] count;

  // The count holds at MAX_CNT so a long stall cannot wrap back to zero and
  // hide the starvation condition from the arbiter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + WAIT_W'(1);
    end
  end

  assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port program/data memory between the RISC-SPM processor
// and the loader/debug port. One grant per cycle, round-robin on ties, an
// optional loader lock for bursts, and a starvation counter that forces a
// processor grant after MAX_WAIT refused cycles.
// Ports:
//   clk, rst                               : clock, async active-low reset
//   cpu_req/we/addr/wdata                  : processor request fields
//   cpu_gnt, cpu_rvalid, cpu_rdata         : processor grant / read return
//   ldr_req/we/addr/wdata, ldr_lock        : loader request fields and lock
//   ldr_gnt, ldr_rvalid, ldr_rdata         : loader grant / read return
//   mem_en/we/addr/wdata                   : memory macro command
//   mem_rdata                              : memory read data (1-cycle latency)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int word_size = risc_spm_pkg::word_size,
  parameter int MAX_WAIT  = 4,
  parameter int WAIT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [word_size-1:0] cpu_addr,
  input  logic [word_size-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [word_size-1:0] cpu_rdata,
  input  logic                 ldr_req,
  input  logic                 ldr_we,
  input  logic [word_size-1:0] ldr_addr,
  input  logic [word_size-1:0] ldr_wdata,
  input  logic                 ldr_lock,
  output logic                 ldr_gnt,
  output logic                 ldr_rvalid,
  output logic [word_size-1:0] ldr_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [word_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  input  logic [word_size-1:0] mem_rdata
);

  import risc_spm_pkg::*;

  arb_state_t state;
  port_id_t   last_gnt;
  logic       cpu_rvalid_q;
  logic       ldr_rvalid_q;
  logic       at_max;
  logic       force_cpu;

  // Processor has waited long enough and still wants the memory.
  assign force_cpu = at_max && cpu_req;

  // Grant decode. Grants are gated by rst so nothing reaches the memory
  // while the block is held in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (rst) begin
      case (state)
        S_RR: begin
          if (cpu_req && ldr_req) begin
            if (last_gnt == PORT_LDR) begin
              cpu_gnt = 1'b1;
            end else begin
              ldr_gnt = 1'b1;
            end
          end else begin
            cpu_gnt = cpu_req;
            ldr_gnt = ldr_req;
          end
        end
        S_LOCK:  ldr_gnt = ldr_req;
        S_FORCE: cpu_gnt = cpu_req;
        default: begin
          cpu_gnt = 1'b0;
          ldr_gnt = 1'b0;
        end
      endcase
    end
  end

  // Memory command mux: idle cycles drive zeros so the macro sees a clean bus.
  always_comb begin
    mem_en    = cpu_gnt | ldr_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  // Arbiter FSM, round-robin history and read-valid pipeline. The forced
  // grant is checked first in every state so a locked loader can never
  // starve the processor indefinitely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_RR;
      last_gnt     <= PORT_LDR;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      ldr_rvalid_q <= ldr_gnt && !ldr_we;

      if (cpu_gnt) begin
        last_gnt <= PORT_CPU;
      end else if (ldr_gnt) begin
        last_gnt <= PORT_LDR;
      end

      case (state)
        S_RR: begin
          if (force_cpu) begin
            state <= S_FORCE;
          end else if (ldr_gnt && ldr_lock) begin
            state <= S_LOCK;
          end
        end
        S_LOCK: begin
          if (force_cpu) begin
            state <= S_FORCE;
          end else if (!ldr_lock || !ldr_req) begin
            state <= S_RR;
          end
        end
        S_FORCE: begin
          if (ldr_lock && ldr_req) begin
            state <= S_LOCK;
          end else begin
            state <= S_RR;
          end
        end
        default: state <= S_RR;
      endcase
    end
  end

  // Read data is only passed through while the matching rvalid is high.
  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
  assign ldr_rdata  = ldr_rvalid_q ? mem_rdata : '0;

  // Starvation counter: counts refused processor cycles, clears on a
  // processor grant or when the processor stops asking.
  arb_wait_counter #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (cpu_req && !cpu_gnt),
    .clr    (!cpu_req || cpu_gnt),
    .at_max (at_max)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scoreboard bench for mem_port_arbiter. Stimulus pushes the grants
// and read returns it expects; a monitor pops and compares them whenever the
// DUT presents a grant or an rvalid. A small memory model answers reads.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  import risc_spm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic       cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [7:0] cpu_rdata, ldr_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [0:255];

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    bit         is_ldr;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } gnt_exp_t;

  typedef struct {
    bit         is_ldr;
    logic [7:0] data;
    int         cyc;
  } rd_exp_t;

  gnt_exp_t gnt_q[$];
  rd_exp_t  rd_q[$];
  gnt_exp_t ge;
  rd_exp_t  re;

  mem_port_arbiter #(.word_size(8), .MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_lock   (ldr_lock),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock and cycle stamp used to check grant/read timing.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro model: synchronous write, read data one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic c_req, input logic c_we,
                               input logic [7:0] c_addr, input logic [7:0] c_wdata,
                               input logic l_req, input logic l_we,
                               input logic [7:0] l_addr, input logic [7:0] l_wdata,
                               input logic l_lock);
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    ldr_req   = l_req;
    ldr_we    = l_we;
    ldr_addr  = l_addr;
    ldr_wdata = l_wdata;
    ldr_lock  = l_lock;
  endtask

  task automatic expectGrant(input bit is_ldr, input bit we,
                             input logic [7:0] addr, input logic [7:0] wdata);
    gnt_exp_t e;
    e = '{is_ldr, we, addr, wdata, cyc};
    gnt_q.push_back(e);
  endtask

  task automatic expectRead(input bit is_ldr, input logic [7:0] data);
    rd_exp_t e;
    e = '{is_ldr, data, cyc + 1};
    rd_q.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, pops an expectation whenever the
  // DUT drives a grant or an rvalid, and checks idle buses are zero.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_gnt || ldr_gnt || mem_en) begin
        if (gnt_q.size() == 0) begin
          checkOutput("unexpected_grant",
                      {cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        end else begin
          ge = gnt_q.pop_front();
          checkOutput("grant",
                      {cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata, cyc[15:0]},
                      {!ge.is_ldr, ge.is_ldr, 1'b1, ge.we, ge.addr, ge.wdata, ge.cyc[15:0]});
        end
      end else begin
        checkOutput("idle_bus_zero", {mem_we, mem_addr, mem_wdata}, 64'd0);
      end

      if (cpu_rvalid || ldr_rvalid) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_rvalid",
                      {cpu_rvalid, ldr_rvalid, cpu_rdata, ldr_rdata}, 64'd0);
        end else begin
          re = rd_q.pop_front();
          checkOutput("read_return",
                      {cpu_rvalid, ldr_rvalid, cpu_rdata, ldr_rdata, cyc[15:0]},
                      {!re.is_ldr, re.is_ldr, (re.is_ldr ? 8'h00 : re.data),
                       (re.is_ldr ? re.data : 8'h00), re.cyc[15:0]});
        end
      end else begin
        checkOutput("rdata_zero_when_invalid", {cpu_rdata, ldr_rdata}, 64'd0);
      end
    end
  end

  // Directed stimulus. Grant and read expectations are hand-derived from the
  // arbitration rules with MAX_WAIT = 4.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h5A;

    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    // Requests during reset must not produce any output activity.
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h11, 8'h00, 1);
    #1;
    checkOutput("reset_outputs",
                {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, mem_we,
                 mem_addr, mem_wdata, cpu_rdata, ldr_rdata}, 64'd0);
    checkOutput("reset_state", dut.state, S_RR);
    nextCycle();

    // Release reset; CPU read of 0x10.
    rst = 1'b1;
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    expectGrant(0, 0, 8'h10, 8'h00);
    expectRead(0, 8'hA5);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    nextCycle();

    // CPU write 0x7F to 0x05: no rvalid afterwards.
    applyStimulus(1, 1, 8'h05, 8'h7F, 0, 0, 8'h00, 8'h00, 0);
    expectGrant(0, 1, 8'h05, 8'h7F);
    nextCycle();

    // Loader read of 0x11 alone, leaving last grant with the loader.
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00, 0);
    expectGrant(1, 0, 8'h11, 8'h00);
    expectRead(1, 8'h5A);
    nextCycle();

    // Both read continuously: CPU, LDR, CPU, LDR.
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h11, 8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        expectGrant(0, 0, 8'h10, 8'h00);
        expectRead(0, 8'hA5);
      end else begin
        expectGrant(1, 0, 8'h11, 8'h00);
        expectRead(1, 8'h5A);
      end
      nextCycle();
    end

    // CPU alone so the next tie goes to the loader.
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    expectGrant(0, 0, 8'h10, 8'h00);
    expectRead(0, 8'hA5);
    nextCycle();

    // Locked loader burst writing 0x33 to 0x20 while the CPU waits:
    // five loader grants, then a forced CPU grant.
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 1, 8'h20, 8'h33, 1);
    for (int k = 0; k < 5; k++) begin
      expectGrant(1, 1, 8'h20, 8'h33);
      if (k == 4) checkOutput("wait_cnt_saturated", dut.u_wait_cnt.count, 64'd4);
      nextCycle();
    end
    checkOutput("state_force", dut.state, S_FORCE);
    expectGrant(0, 0, 8'h10, 8'h00);
    expectRead(0, 8'hA5);
    nextCycle();

    // Loader resumes its lock; CPU waits two cycles.
    checkOutput("state_relock", dut.state, S_LOCK);
    for (int k = 0; k < 2; k++) begin
      expectGrant(1, 1, 8'h20, 8'h33);
      nextCycle();
    end

    // Lock released: loader still granted this cycle, then CPU wins.
    checkOutput("wait_cnt_two", dut.u_wait_cnt.count, 64'd2);
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 1, 8'h20, 8'h33, 0);
    expectGrant(1, 1, 8'h20, 8'h33);
    nextCycle();
    checkOutput("state_rr_after_unlock", dut.state, S_RR);
    expectGrant(0, 0, 8'h10, 8'h00);
    expectRead(0, 8'hA5);
    nextCycle();

    // Loader reads back the burst data.
    checkOutput("wait_cnt_cleared", dut.u_wait_cnt.count, 64'd0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0);
    expectGrant(1, 0, 8'h20, 8'h00);
    expectRead(1, 8'h33);
    nextCycle();

    // CPU read, then a loader read interrupted by reset before its rvalid.
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    expectGrant(0, 0, 8'h10, 8'h00);
    expectRead(0, 8'hA5);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00, 0);
    expectGrant(1, 0, 8'h11, 8'h00);
    #6;
    rst = 1'b0;
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h11, 8'h00, 0);
    nextCycle();
    nextCycle();
    checkOutput("midread_reset_outputs",
                {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, mem_we,
                 mem_addr, mem_wdata, cpu_rdata, ldr_rdata}, 64'd0);
    checkOutput("midread_reset_state", dut.state, S_RR);

    // First tie after reset goes to the CPU.
    rst = 1'b1;
    expectGrant(0, 0, 8'h10, 8'h00);
    expectRead(0, 8'hA5);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    repeat (3) nextCycle();

    checkOutput("grant_queue_drained", gnt_q.size(), 64'd0);
    checkOutput("read_queue_drained", rd_q.size(), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
